// File: rtl/dmem_dump_arbiter.sv
// ============================================================================
//  Module   : dmem_dump_arbiter
//  Brief    : Shares the data-RAM port between the MEM stage and a debug dump
//             that streams the first DUMP_WORDS words out as bytes, MSB first.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_dump_arbiter #(
    parameter int LEN        = 32,
    parameter int DUMP_WORDS = 32,
    parameter int IDX_W      = $clog2(DUMP_WORDS) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           halt_flag,
    input  logic           dump_start,
    input  logic [LEN-1:0] pipe_addr,
    input  logic [LEN-1:0] pipe_wdata,
    input  logic           pipe_we,
    input  logic           pipe_re,
    output logic [LEN-1:0] ram_addr,
    output logic [LEN-1:0] ram_din,
    output logic           ram_we,
    output logic           ram_en,
    input  logic [LEN-1:0] ram_dout,
    output logic [7:0]     tx_byte,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           busy,
    output logic           dump_done,
    output logic           dump_err
);

    typedef enum logic [2:0] {
        S_PIPE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_TX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DUMP_WORDS - 1);

    state_t           r_state_q, w_state_d;
    logic [IDX_W-1:0] r_widx_q,  w_widx_d;
    logic [1:0]       r_bidx_q,  w_bidx_d;
    logic [LEN-1:0]   r_word_q,  w_word_d;
    logic             r_err_q,   w_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_PIPE;
            r_widx_q  <= '0;
            r_bidx_q  <= '0;
            r_word_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_widx_q  <= w_widx_d;
            r_bidx_q  <= w_bidx_d;
            r_word_q  <= w_word_d;
            r_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_widx_d  = r_widx_q;
        w_bidx_d  = r_bidx_q;
        w_word_d  = r_word_q;
        w_err_d   = 1'b0;
        case (r_state_q)
            S_PIPE: begin
                if (dump_start) begin
                    if (halt_flag) begin
                        w_state_d = S_RD;
                        w_widx_d  = '0;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            S_RD:  w_state_d = S_CAP;
            S_CAP: begin
                w_word_d  = ram_dout;
                w_bidx_d  = '0;
                w_state_d = S_TX;
            end
            S_TX: begin
                if (tx_ready) begin
                    w_bidx_d = r_bidx_q + 2'd1;
                    // Fourth byte of the word leaves on this handshake
                    if (r_bidx_q == 2'd3) begin
                        if (r_widx_q == C_LAST_IDX) begin
                            w_state_d = S_DONE;
                        end else begin
                            w_widx_d  = r_widx_q + 1'b1;
                            w_state_d = S_RD;
                        end
                    end
                end
            end
            S_DONE:  w_state_d = S_PIPE;
            default: w_state_d = S_PIPE;
        endcase
    end

    always_comb begin
        busy      = (r_state_q != S_PIPE);
        dump_done = (r_state_q == S_DONE);
        dump_err  = r_err_q;
        tx_valid  = (r_state_q == S_TX);
        tx_byte   = 8'h00;
        if (r_state_q == S_TX) begin
            case (r_bidx_q)
                2'd0:    tx_byte = r_word_q[31:24];
                2'd1:    tx_byte = r_word_q[23:16];
                2'd2:    tx_byte = r_word_q[15:8];
                default: tx_byte = r_word_q[7:0];
            endcase
        end
        if (r_state_q == S_PIPE) begin
            ram_addr = pipe_addr;
            ram_din  = pipe_wdata;
            ram_we   = pipe_we;
            ram_en   = pipe_re | pipe_we;
        end else begin
            ram_addr = LEN'(r_widx_q);
            ram_din  = '0;
            ram_we   = 1'b0;
            ram_en   = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_dump_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_dump_arbiter
//  Brief    : Directed, table-driven bench for dmem_dump_arbiter with a small
//             registered-read RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_dump_arbiter;

    localparam int LEN = 32;
    localparam int DW  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            halt_flag;
    logic            dump_start;
    logic [LEN-1:0]  pipe_addr;
    logic [LEN-1:0]  pipe_wdata;
    logic            pipe_we;
    logic            pipe_re;
    logic [LEN-1:0]  ram_addr;
    logic [LEN-1:0]  ram_din;
    logic            ram_we;
    logic            ram_en;
    logic [LEN-1:0]  ram_dout;
    logic [7:0]      tx_byte;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            dump_done;
    logic            dump_err;

    dmem_dump_arbiter #(.LEN(LEN), .DUMP_WORDS(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .halt_flag  (halt_flag),
        .dump_start (dump_start),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_we    (pipe_we),
        .pipe_re    (pipe_re),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_en     (ram_en),
        .ram_dout   (ram_dout),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .dump_done  (dump_done),
        .dump_err   (dump_err)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model, 64 words
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[5:0]] <= ram_din;
            ram_dout <= mem[ram_addr[5:0]];
        end
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        halt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] e_addr;
        logic [31:0] e_din;
        logic        e_we;
        logic        e_en;
    } vec_t;

    vec_t vecs [4];

    logic [7:0] exp_bytes [8];

    // Runs one dump with halt_flag=1 and checks byte stream, timing and pulses.
    // stall_len: cycles of tx_ready=0 while byte index 1 is offered.
    // disturb: drop halt_flag and re-pulse dump_start mid-dump.
    task automatic run_dump(input string tag, input int stall_len, input bit disturb,
                            input int exp_cycles);
        int  nbytes = 0;
        int  ndone = 0;
        int  nerr = 0;
        int  nwe = 0;
        int  stalled = 0;
        int  stall_bad = 0;
        int  cyc = 0;
        int  byte_bad = 0;
        bit  finished = 0;
        halt_flag = 1'b1;
        @(negedge clk);
        dump_start = 1'b1;
        for (int c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk);
            dump_start = 1'b0;
            if (disturb && c == 3) halt_flag = 1'b0;
            if (disturb && tx_valid && nbytes == 4) dump_start = 1'b1;
            if (dump_err) nerr++;
            if (busy && ram_we) nwe++;
            if (dump_done) begin
                ndone++;
                cyc = c;
                finished = 1;
            end
            tx_ready = 1'b1;
            if (nbytes == 1 && stalled < stall_len) begin
                tx_ready = 1'b0;
                stalled++;
                if (!(tx_valid && tx_byte == 8'h22)) stall_bad++;
            end
            if (tx_valid && tx_ready) begin
                if (nbytes < 8 && tx_byte != exp_bytes[nbytes]) begin
                    byte_bad++;
                    $display("FAIL %s byte%0d: got 0x%0h expected 0x%0h",
                             tag, nbytes, tx_byte, exp_bytes[nbytes]);
                end
                nbytes++;
            end
        end
        @(negedge clk);
        dump_start = 1'b0;
        if (dump_err) nerr++;
        chk({tag, " bytes_count"}, nbytes, 8);
        chk({tag, " bytes_order"}, byte_bad, 0);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " cycles"}, cyc, exp_cycles);
        chk({tag, " no_err"}, nerr, 0);
        chk({tag, " ram_we_low"}, nwe, 0);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " valid_after"}, tx_valid, 0);
        if (stall_len > 0) chk({tag, " stall_hold"}, stall_bad, 0);
        halt_flag = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h10, 32'hCAFEBABE, 1'b1, 1'b0, 32'h10, 32'hCAFEBABE, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h24, 32'h0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h8, 32'h12345678, 1'b0, 1'b0, 32'h8, 32'h12345678, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFFFFFC, 32'hDEADBEEF, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hDEADBEEF, 1'b1, 1'b1};
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;

        reset = 1'b1; halt_flag = 1'b0; dump_start = 1'b0;
        pipe_addr = '0; pipe_wdata = '0; pipe_we = 1'b0; pipe_re = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_byte", tx_byte, 0);
        chk("reset dump_done", dump_done, 0);
        chk("reset dump_err", dump_err, 0);

        // Run-mode pass-through
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            halt_flag = vecs[i].halt; pipe_addr = vecs[i].addr; pipe_wdata = vecs[i].wdata;
            pipe_we = vecs[i].we; pipe_re = vecs[i].re;
            #1;
            chk($sformatf("mux%0d ram_addr", i), ram_addr, vecs[i].e_addr);
            chk($sformatf("mux%0d ram_din", i), ram_din, vecs[i].e_din);
            chk($sformatf("mux%0d ram_we", i), ram_we, vecs[i].e_we);
            chk($sformatf("mux%0d ram_en", i), ram_en, vecs[i].e_en);
            chk($sformatf("mux%0d busy", i), busy, 0);
        end
        @(negedge clk);
        pipe_we = 1'b0; pipe_re = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        @(negedge clk);

        // Rejected request while running
        halt_flag = 1'b0;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        chk("reject dump_err", dump_err, 1);
        chk("reject busy", busy, 0);
        chk("reject tx_valid", tx_valid, 0);
        chk("reject dump_done", dump_done, 0);
        @(negedge clk);
        chk("reject err_one_cycle", dump_err, 0);

        run_dump("dump", 0, 1'b0, 13);
        run_dump("stall", 5, 1'b0, 18);
        run_dump("disturb", 0, 1'b1, 13);

        // Reset during word 1 transmit
        begin
            int got = 0;
            bit hit = 0;
            halt_flag = 1'b1;
            tx_ready = 1'b1;
            @(negedge clk);
            dump_start = 1'b1;
            for (int c = 0; c < 100 && !hit; c++) begin
                @(negedge clk);
                dump_start = 1'b0;
                if (tx_valid && got == 5) hit = 1;
                else if (tx_valid) got++;
            end
            chk("rst_mid reached_word1", hit, 1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_mid busy", busy, 0);
            chk("rst_mid tx_valid", tx_valid, 0);
        end
        run_dump("after_rst", 0, 1'b0, 13);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
